// File: rtl/buffer_stream_reader.sv
// Read sequencer for the banked buffer's mode-0 port: walks a bank/address window,
// absorbs the 1-cycle read latency and presents the words as a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, throttled by FIFO occupancy
// DRAIN | all reads issued, emptying the FIFO
// DONE  | one-cycle done pulse
module buffer_stream_reader #(
  parameter int N_BUF      = 8,
  parameter int LOG_N_BUF  = 3,
  parameter int ADDR_RAM   = 10,
  parameter int WID        = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LOG_N_BUF-1:0] cfg_bank_first,
  input  logic [LOG_N_BUF-1:0] cfg_bank_last,
  input  logic [ADDR_RAM-1:0]  cfg_addr_base,
  input  logic [ADDR_RAM:0]    cfg_len,
  output logic                 buf_mode,
  output logic                 buf_r_en,
  output logic [LOG_N_BUF-1:0] buf_r_sel,
  output logic [ADDR_RAM-1:0]  buf_r_addr,
  input  logic [WID-1:0]       buf_r_data,
  output logic [WID-1:0]       out_data,
  output logic [LOG_N_BUF-1:0] out_bank,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TAG_W = WID + LOG_N_BUF + 1;
  localparam logic [LOG_N_BUF-1:0] BANK_MAX = LOG_N_BUF'(N_BUF - 1);
  localparam logic [LOG_N_BUF-1:0] BANK_ONE = LOG_N_BUF'(1);
  localparam logic [ADDR_RAM-1:0]  ADDR_ONE = ADDR_RAM'(1);
  localparam logic [ADDR_RAM:0]    LEN_ONE  = (ADDR_RAM + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [LOG_N_BUF-1:0] bank_last_q, ptr_bank_q, hold_sel_q, infl_bank_q;
  logic [ADDR_RAM-1:0]  addr_base_q, ptr_addr_q, hold_addr_q;
  logic [ADDR_RAM:0]    len_q, cnt_q;
  logic                 inflight_q, infl_last_q, err_q;

  logic [TAG_W-1:0] fifo_q [FIFO_DEPTH];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  logic       pop, push, issue, start_ok, cfg_bad, rd_last, can_issue;
  logic [2:0] occ;

  assign cfg_bad  = cfg_bank_last < cfg_bank_first;
  assign start_ok = (state_q == S_IDLE) && start && !abort;
  assign pop      = (count_q != 2'd0) && out_ready;
  assign push     = inflight_q && !abort;
  assign rd_last  = (ptr_bank_q == bank_last_q) && (cnt_q == LEN_ONE);

  // Occupancy after this cycle's pop must leave room for the word this read returns.
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q};
  assign can_issue = occ < (3'd2 + {2'b00, pop});
  assign issue     = (state_q == S_RUN) && !abort && can_issue;

  assign buf_mode   = 1'b0;
  assign buf_r_en   = issue;
  assign buf_r_sel  = issue ? ptr_bank_q : hold_sel_q;
  assign buf_r_addr = issue ? ptr_addr_q : hold_addr_q;

  assign {out_last, out_bank, out_data} = fifo_q[rd_ptr_q];
  assign out_valid = count_q != 2'd0;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok && !cfg_bad) state_d = (cfg_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issue && rd_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bank_last_q <= '0;
      addr_base_q <= '0;
      len_q       <= '0;
      ptr_bank_q  <= '0;
      ptr_addr_q  <= '0;
      cnt_q       <= '0;
      hold_sel_q  <= '0;
      hold_addr_q <= '0;
      inflight_q  <= 1'b0;
      infl_bank_q <= '0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_ok && cfg_bad;
      if (start_ok) begin
        bank_last_q <= cfg_bank_last;
        addr_base_q <= cfg_addr_base;
        len_q       <= cfg_len;
        ptr_bank_q  <= cfg_bank_first;
        ptr_addr_q  <= cfg_addr_base;
        cnt_q       <= cfg_len;
      end else if (issue) begin
        hold_sel_q  <= ptr_bank_q;
        hold_addr_q <= ptr_addr_q;
        // Address wraps modulo 2^ADDR_RAM; only the per-bank count moves the bank.
        if (cnt_q == LEN_ONE) begin
          if (ptr_bank_q != BANK_MAX) ptr_bank_q <= ptr_bank_q + BANK_ONE;
          ptr_addr_q <= addr_base_q;
          cnt_q      <= len_q;
        end else begin
          ptr_addr_q <= ptr_addr_q + ADDR_ONE;
          cnt_q      <= cnt_q - LEN_ONE;
        end
      end
      inflight_q <= issue;
      if (issue) begin
        infl_bank_q <= ptr_bank_q;
        infl_last_q <= rd_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (abort) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {infl_last_q, infl_bank_q, buf_r_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Bench for buffer_stream_reader: directed and random transfers against a queue-based
// model of the expected read sequence and output word stream.
module tb_buffer_stream_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  cfg_bank_first, cfg_bank_last;
  logic [9:0]  cfg_addr_base;
  logic [10:0] cfg_len;
  logic        buf_mode, buf_r_en;
  logic [2:0]  buf_r_sel;
  logic [9:0]  buf_r_addr;
  logic [15:0] buf_r_data;
  logic [15:0] out_data;
  logic [2:0]  out_bank;
  logic        out_last, out_valid, out_ready, busy, done, err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] salt  = 16'h0;

  buffer_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_bank_first(cfg_bank_first), .cfg_bank_last(cfg_bank_last),
    .cfg_addr_base(cfg_addr_base), .cfg_len(cfg_len),
    .buf_mode(buf_mode), .buf_r_en(buf_r_en), .buf_r_sel(buf_r_sel),
    .buf_r_addr(buf_r_addr), .buf_r_data(buf_r_data),
    .out_data(out_data), .out_bank(out_bank), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [2:0] b, input logic [9:0] a);
    return {b, a, 3'b000} ^ salt;
  endfunction

  // Buffer model: one-cycle read latency, garbage when not reading.
  always @(posedge clk)
    buf_r_data <= buf_r_en ? data_of(buf_r_sel, buf_r_addr) : 16'($urandom);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode: 0 ready=1, 1 ready toggling 1010, 2 random ready, 3 ready low for cycles 6..25
  task automatic run_xfer(input logic [2:0] bf, input logic [2:0] bl, input logic [9:0] base,
                          input logic [10:0] len, input int mode, input int abort_at,
                          input bit timing);
    logic [2:0]  rb[$];
    logic [9:0]  ra[$];
    logic [19:0] ew[$];
    int   issued = 0, hs = 0, n_en = 0, n_done = 0, n_err = 0, total = 0;
    int   done_cyc = -1, err_cyc = -1, first_en = -1, first_val = -1, last_hs = -1;
    int   en_after_abort = 0, busy_seen = 0, hs_rel = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0;
    logic [19:0] prev_word = '0;
    bit   illegal = bl < bf;
    bit   finished = 1'b0;
    salt = 16'($urandom);
    if (!illegal)
      for (int b = int'(bf); b <= int'(bl); b++)
        for (int i = 0; i < int'(len); i++) begin
          logic [9:0] a;
          a = 10'((int'(base) + i) % 1024);
          rb.push_back(3'(b));
          ra.push_back(a);
          ew.push_back({(b == int'(bl)) && (i == int'(len) - 1), 3'(b), data_of(3'(b), a)});
        end
    total = rb.size();
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      logic pop_now;
      @(posedge clk); #1;
      start = (cyc == 0);
      abort = (cyc == abort_at);
      if (cyc == 0) begin
        cfg_bank_first = bf; cfg_bank_last = bl; cfg_addr_base = base; cfg_len = len;
      end else begin
        cfg_bank_first = 3'($urandom); cfg_bank_last = 3'($urandom);
        cfg_addr_base = 10'($urandom); cfg_len = 11'($urandom);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 6 && cyc < 26);
      endcase
      @(negedge clk);
      pop_now = out_valid && out_ready;
      if (cyc == 0) check_val("busy_at_start", busy, 0);
      if (busy) busy_seen++;
      if (buf_r_en) begin
        n_en++;
        if (first_en < 0) first_en = cyc;
        if (abort_at >= 0 && cyc > abort_at) en_after_abort++;
        check_val("occupancy_lt2", (issued - hs - int'(pop_now)) < 2, 1);
        if (rb.size() == 0) check_val("extra_read", 1, 0);
        else begin
          check_val("read_sel", buf_r_sel, rb.pop_front());
          check_val("read_addr", buf_r_addr, ra.pop_front());
        end
        issued++;
      end
      if (prev_valid && !prev_hs && cyc != abort_at + 1)
        check_val("hold", {out_valid, out_last, out_bank, out_data}, {1'b1, prev_word});
      if (out_valid && first_val < 0) first_val = cyc;
      if (pop_now) begin
        if (ew.size() == 0) check_val("extra_word", 1, 0);
        else check_val("word", {out_last, out_bank, out_data}, ew.pop_front());
        hs++;
        last_hs = cyc;
        if (mode == 3 && cyc >= 26) hs_rel++;
      end
      prev_valid = out_valid;
      prev_hs    = pop_now;
      prev_word  = {out_last, out_bank, out_data};
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
      if (done_cyc >= 0 && cyc == done_cyc + 1) check_val("busy_after_done", busy, 0);
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        check_val("abort_valid", out_valid, 0);
        check_val("abort_busy", busy, 0);
      end
      if (abort_at >= 0)  finished = cyc >= abort_at + 5;
      else if (illegal)   finished = cyc >= 6;
      else                finished = done_cyc >= 0 && cyc >= done_cyc + 2;
    end
    if (!finished) check_val("timeout", 1, 0);
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    if (abort_at >= 0) begin
      check_val("abort_no_done", n_done, 0);
      check_val("abort_no_reads_after", en_after_abort, 0);
    end else if (illegal) begin
      check_val("illegal_err_count", n_err, 1);
      check_val("illegal_err_cycle", err_cyc, 1);
      check_val("illegal_reads", n_en, 0);
      check_val("illegal_busy", busy_seen, 0);
      check_val("illegal_done", n_done, 0);
    end else begin
      check_val("read_count", n_en, total);
      check_val("word_count", hs, total);
      check_val("done_count", n_done, 1);
      check_val("no_err", n_err, 0);
      if (total > 0) check_val("done_after_last", done_cyc, last_hs + 1);
      else           check_val("done_len0", done_cyc, 1);
      if (timing) begin
        check_val("first_read_cycle", first_en, 1);
        check_val("first_valid_cycle", first_val, 3);
        check_val("full_rate", last_hs - first_val, total - 1);
      end
      if (mode == 3) check_val("resume_no_gap", hs_rel, last_hs - 26 + 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_bank_first = '0; cfg_bank_last = '0; cfg_addr_base = '0; cfg_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", {buf_mode, buf_r_en, buf_r_sel, buf_r_addr, out_data, out_bank,
                                out_last, out_valid, busy, done, err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_reset_outputs", {buf_mode, buf_r_en, buf_r_sel, buf_r_addr, out_data,
                                     out_bank, out_last, out_valid, busy, done, err}, 0);

    run_xfer(3'd2, 3'd2, 10'd5, 11'd4, 0, -1, 1'b1);
    run_xfer(3'd0, 3'd3, 10'd0, 11'd3, 1, -1, 1'b0);
    run_xfer(3'd6, 3'd6, 10'd1022, 11'd4, 0, -1, 1'b0);
    run_xfer(3'd1, 3'd4, 10'd100, 11'd0, 0, -1, 1'b0);
    run_xfer(3'd5, 3'd3, 10'd7, 11'd4, 0, -1, 1'b0);
    run_xfer(3'd0, 3'd7, 10'd200, 11'd50, 3, 12, 1'b0);
    run_xfer(3'd1, 3'd1, 10'd0, 11'd3, 0, 2, 1'b0);
    run_xfer(3'd2, 3'd2, 10'd5, 11'd4, 0, -1, 1'b1);
    run_xfer(3'd3, 3'd5, 10'd700, 11'd10, 3, -1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      logic [2:0] f, l;
      f = 3'($urandom_range(0, 7));
      l = 3'($urandom_range(int'(f), 7));
      run_xfer(f, l, 10'($urandom), 11'($urandom_range(0, 40)), 2, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
